// File: rtl/if_fetch_stage_pkg.sv
// rv32_pkg: shared constants and fetch state encoding for the RV32 fetch stage.
package rv32_pkg;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;
   localparam logic [31:0] PC_INC = 32'd4;
   typedef enum logic [1:0] {FETCH, FULL, KILL} fetch_state_e;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: single-outstanding request/ack instruction-memory port.
interface if_fetch_stage_if;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic        imem_ack_in;
   logic [31:0] imem_data_in;
   modport master (output imem_req_out, imem_addr_out, input imem_ack_in, imem_data_in);
   modport slave (input imem_req_out, imem_addr_out, output imem_ack_in, imem_data_in);
endinterface

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry {pc,insn} buffer catching a fetch that returns while the stage is held.
module if_skid_buf
   import rv32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        drain_i,
   input  logic        clear_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] insn_i,
   output logic        full_o,
   output logic [31:0] pc_o,
   output logic [31:0] insn_o
);
   logic        full_q;
   logic [31:0] pc_q, insn_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         full_q <= 1'b0;
         pc_q   <= RESET_PC_DEF;
         insn_q <= NOP_INSN_DEF;
      end else if (clear_i || drain_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         full_q <= 1'b1;
         pc_q   <= pc_i;
         insn_q <= insn_i;
      end
   assign full_o = full_q;
   assign pc_o   = pc_q;
   assign insn_o = insn_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32 instruction fetch; owns the PC, drives imem, presents pc/insn to the bubble unit.
module if_fetch_stage
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   if_fetch_stage_if.master         imem,
   input  logic                     hold_pc_in,
   input  logic                     redirect_in,
   input  logic [31:0]              redirect_pc_in,
   output logic [31:0]              pc_if_out,
   output logic [31:0]              data_if_out,
   output logic                     valid_if_out
);
   fetch_state_e state_q;
   logic [31:0]  pc_q, kill_addr_q, pc_if_q, data_if_q;
   logic         valid_q;
   logic         ack, buf_full;
   logic [31:0]  pc_d, tgt_d, buf_pc, buf_insn;
   assign imem.imem_req_out  = rst && state_q != FULL;
   assign imem.imem_addr_out = state_q == KILL ? kill_addr_q : pc_q;
   assign ack   = imem.imem_ack_in && imem.imem_req_out;
   assign pc_d  = pc_q + PC_INC;
   assign tgt_d = redirect_pc_in & ~32'h3;
   if_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (state_q == FETCH && ack && hold_pc_in && !redirect_in),
      .drain_i (state_q == FULL && !hold_pc_in && !redirect_in),
      .clear_i (redirect_in),
      .pc_i    (pc_q),
      .insn_i  (imem.imem_data_in),
      .full_o  (buf_full),
      .pc_o    (buf_pc),
      .insn_o  (buf_insn)
   );
   // Redirect wins over everything; an unanswered request must still be drained in KILL.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         kill_addr_q <= RESET_PC;
         pc_if_q     <= RESET_PC;
         data_if_q   <= NOP_INSN;
         valid_q     <= 1'b0;
      end else if (redirect_in) begin
         pc_q      <= tgt_d;
         valid_q   <= 1'b0;
         data_if_q <= NOP_INSN;
         state_q   <= (state_q != FULL && !ack) ? KILL : FETCH;
         if (state_q == FETCH) kill_addr_q <= pc_q;
      end else begin
         case (state_q)
            FETCH:
               if (ack) begin
                  pc_q <= pc_d;
                  if (hold_pc_in) state_q <= FULL;
                  else begin
                     pc_if_q   <= pc_q;
                     data_if_q <= imem.imem_data_in;
                     valid_q   <= 1'b1;
                  end
               end else if (!hold_pc_in) begin
                  valid_q   <= 1'b0;
                  data_if_q <= NOP_INSN;
               end
            FULL:
               if (!hold_pc_in) begin
                  pc_if_q   <= buf_pc;
                  data_if_q <= buf_insn;
                  valid_q   <= buf_full;
                  state_q   <= FETCH;
               end
            KILL:
               if (ack) state_q <= FETCH;
            default: state_q <= FETCH;
         endcase
      end
   assign pc_if_out    = pc_if_q;
   assign data_if_out  = data_if_q;
   assign valid_if_out = valid_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vectors against a latency-programmable instruction memory.
module tb_if_fetch_stage;
   import rv32_pkg::*;
   logic        clk = 1'b0, rst = 1'b1, hold = 1'b0, redir = 1'b0, spur = 1'b0;
   logic [31:0] rpc = 32'h0, pc_if, data_if;
   logic        valid;
   int          lat = 0, cnt, n_vec = 0, n_err = 0;
   localparam logic [31:0] NOP = 32'h0000_0013;
   if_fetch_stage_if imem ();
   if_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem),
      .hold_pc_in     (hold),
      .redirect_in    (redir),
      .redirect_pc_in (rpc),
      .pc_if_out      (pc_if),
      .data_if_out    (data_if),
      .valid_if_out   (valid)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction
   always_comb begin
      imem.imem_ack_in  = spur || (imem.imem_req_out && cnt >= lat);
      imem.imem_data_in = word(imem.imem_addr_out);
   end
   always @(posedge clk or negedge rst)
      cnt <= !rst ? 0 : (imem.imem_req_out && !imem.imem_ack_in) ? cnt + 1 : 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic out(input string tag, input logic [31:0] pc, input logic [31:0] d, input logic v);
      check({tag, ".pc"}, pc_if, pc);
      check({tag, ".data"}, data_if, d);
      check({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
   endtask
   initial begin
      #1 rst = 1'b0;
      #1;
      check("rst.req", {31'b0, imem.imem_req_out}, 32'h0);
      out("rst", 32'h0, NOP, 1'b0);
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out("seq", 32'(4 * i), word(32'(4 * i)), 1'b1);
      end
      lat = 1;
      @(negedge clk) out("lat_bub", 32'h8, NOP, 1'b0);
      @(negedge clk) out("lat_hit", 32'hC, word(32'hC), 1'b1);
      hold = 1'b1;
      @(negedge clk) out("hold0", 32'hC, word(32'hC), 1'b1);
      @(negedge clk) out("hold1", 32'hC, word(32'hC), 1'b1);
      check("full.req", {31'b0, imem.imem_req_out}, 32'h0);
      spur = 1'b1;
      @(negedge clk) out("hold2", 32'hC, word(32'hC), 1'b1);
      check("full.req2", {31'b0, imem.imem_req_out}, 32'h0);
      spur = 1'b0;
      hold = 1'b0;
      @(negedge clk) out("drain", 32'h10, word(32'h10), 1'b1);
      check("drain.addr", imem.imem_addr_out, 32'h14);
      lat = 0;
      @(negedge clk) out("after", 32'h14, word(32'h14), 1'b1);
      repeat (2) @(negedge clk);
      check("run.pc", pc_if, 32'h1C);
      lat = 3;
      @(negedge clk) out("pend", 32'h1C, NOP, 1'b0);
      redir = 1'b1;
      rpc = 32'h0000_0203;
      @(negedge clk) redir = 1'b0;
      out("kill", 32'h1C, NOP, 1'b0);
      check("kill.addr", imem.imem_addr_out, 32'h20);
      check("kill.req", {31'b0, imem.imem_req_out}, 32'h1);
      @(negedge clk) check("kill.addr2", imem.imem_addr_out, 32'h20);
      check("kill.valid", {31'b0, valid}, 32'h0);
      lat = 0;
      @(negedge clk) check("tgt.addr", imem.imem_addr_out, 32'h200);
      check("tgt.valid", {31'b0, valid}, 32'h0);
      @(negedge clk) out("tgt_first", 32'h200, word(32'h200), 1'b1);
      hold = 1'b1;
      @(negedge clk) check("rh.req", {31'b0, imem.imem_req_out}, 32'h0);
      redir = 1'b1;
      rpc = 32'h0000_0300;
      @(negedge clk) redir = 1'b0;
      hold = 1'b0;
      out("rh", 32'h200, NOP, 1'b0);
      check("rh.addr", imem.imem_addr_out, 32'h300);
      @(negedge clk) out("rh_next", 32'h300, word(32'h300), 1'b1);
      redir = 1'b1;
      rpc = 32'hFFFF_FFFF;
      @(negedge clk) redir = 1'b0;
      check("wrap.addr", imem.imem_addr_out, 32'hFFFF_FFFC);
      check("wrap.valid", {31'b0, valid}, 32'h0);
      @(negedge clk) out("wrap", 32'hFFFF_FFFC, word(32'hFFFF_FFFC), 1'b1);
      check("wrap.next", imem.imem_addr_out, 32'h0);
      @(negedge clk) out("wrap0", 32'h0, word(32'h0), 1'b1);
      @(negedge clk) out("pre_rst", 32'h4, word(32'h4), 1'b1);
      lat = 3;
      #2 rst = 1'b0;
      #1 check("arst.req", {31'b0, imem.imem_req_out}, 32'h0);
      out("arst", 32'h0, NOP, 1'b0);
      @(negedge clk) lat = 0;
      rst = 1'b1;
      check("rel.addr", imem.imem_addr_out, 32'h0);
      @(negedge clk) out("rel_first", 32'h0, word(32'h0), 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RV32 5-stage pipeline; sits directly upstream of the IF/ID register and the load-use bubble unit.
- Owns the PC register and drives a single-outstanding request/ack instruction-memory port.
- Produces pc_if/data_if for the bubble unit, freezes under hold_pc and redirects on taken branch/jump.
- Pending fetches are buffered or discarded so no instruction is lost or duplicated.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSN, 32'h0000_0013, instruction word emitted when the output is invalid (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- hold_pc_in  in  1  stall from the bubble unit: freeze PC and outputs.
- redirect_in  in  1  taken branch/jump from EX; flush fetch.
- redirect_pc_in  in  32  redirect target; bits[1:0] ignored (forced 0).
- imem_req_out  out  1  fetch request.
- imem_addr_out  out  32  fetch address, word aligned.
- imem_ack_in  in  1  memory returns data; legal in the same cycle as req or later.
- imem_data_in  in  32  instruction word, valid when ack=1.
- pc_if_out  out  32  PC of the presented instruction.
- data_if_out  out  32  presented instruction word.
- valid_if_out  out  1  pc_if_out/data_if_out hold a real instruction.

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC, state=FETCH, skid buffer empty.
  - pc_if_out=RESET_PC, data_if_out=NOP_INSN, valid_if_out=0.
  - imem_req_out=0 while rst=0.
- Memory protocol:
  - req and addr are stable from assertion until the cycle ack=1 (inclusive).
  - One outstanding request at a time.
  - ack while req=0 is ignored.
  - Combinational path ack->outputs is forbidden; all outputs are registered except imem_req_out/imem_addr_out, which are decoded from state/pc.
- States:
  - FETCH: req=1, addr=pc.
    - ack & !hold & !redirect: outputs <= {pc, imem_data_in, 1}; pc <= pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC->0); stay.
    - ack & hold & !redirect: buffer <= {pc, data}; pc <= pc+4; go FULL; outputs unchanged.
    - no ack & !redirect: outputs unchanged while hold=1; otherwise valid_if_out<=0, data<=NOP_INSN (bubble), pc_if_out unchanged.
  - FULL: req=0.
    - !hold & !redirect: outputs <= buffer; buffer empty; go FETCH.
    - hold: remain.
  - KILL: req=1, addr=old stale address.
    - ack: data discarded; go FETCH with pc already equal to the target.
    - No output update in this state; valid_if_out stays 0.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc_in[31:2],2'b00}.
  - valid_if_out<=0, data_if_out<=NOP_INSN; buffer cleared.
  - If in FETCH with no ack this cycle: go KILL; otherwise go FETCH.
  - Redirect overrides hold; the flushed instruction is dead.
- hold with no request activity: all registers hold value exactly.
- Hold asserted the same cycle outputs were just loaded: the loaded value is held, not advanced.
- Reset mid-request: state returns to FETCH; any ack for the aborted request arriving after reset release is treated as the response to the new RESET_PC request only if req=1 at that time. Memory is reset with the same rst, so no stale ack exists.

Decomposition:
- Shared package (rv32_pkg): RESET_PC default, NOP_INSN constant, fetch state enum {FETCH, FULL, KILL}, PC_INC=4.
- One sub-module is natural: if_skid_buf, a 1-entry {pc,insn} buffer with load/drain/clear.

Test Plan:
- Reset release, memory ack same cycle -> pc_if_out sequence 0x0,0x4,0x8 on consecutive cycles, valid=1, data matches memory words.
- Ack latency 2 cycles -> every other cycle valid=0 with data_if_out=0x00000013, pc_if_out advancing by 4 per delivered instruction.
- hold_pc_in=1 for 3 cycles while ack arrives for pc=0x10 -> outputs frozen at pc 0x0C; after hold drops, next output pc=0x10 from buffer, then 0x14; no duplicate or skipped pc.
- redirect_in=1, redirect_pc_in=0x0000_0203 while a fetch of 0x20 is outstanding -> state KILL, data for 0x20 discarded, next imem_addr_out=0x200, first valid output pc=0x200.
- redirect and hold in the same cycle in FULL -> buffer cleared, valid=0, next fetch at target.
- PC at 0xFFFF_FFFC fetched -> next pc=0x0000_0000; async rst pulse mid-request -> outputs immediately pc=RESET_PC, valid=0, req=0.
